// File: rtl/internalram_busctrl_pkg.sv
// internalram_busctrl_pkg: bus-sequencer state encoding and internal-RAM map defaults
// Exports: bus_state_e (3-bit binary FSM states), IRAM_BASE, IRAM_AW
package tang68k_pkg;
   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_DECODE  = 3'd1,
      S_READ    = 3'd2,
      S_WRITE   = 3'd3,
      S_ACK     = 3'd4,
      S_RELEASE = 3'd5
   } bus_state_e;
   localparam logic [23:0] IRAM_BASE = 24'h10_0000;
   localparam int          IRAM_AW   = 12;
endpackage

// File: rtl/internalram_busctrl_if.sv
// internalram_busctrl_if: 68000 pin bundle plus the two-lane internal RAM port
// slave: bus controller side; master: CPU pins and RAM instance side
interface internalram_busctrl_if import tang68k_pkg::*; #(parameter int AW = IRAM_AW);
   logic          cpu_as_n, cpu_uds_n, cpu_lds_n, cpu_rw;
   logic [23:1]   cpu_addr;
   logic [15:0]   cpu_data_in, cpu_data_out;
   logic          cpu_data_oe, cpu_dtack_n;
   logic [AW-1:0] ram_addr;
   logic [15:0]   ram_wdata, ram_rdata;
   logic          ram_we_hi, ram_we_lo;
   modport slave (
      input  cpu_as_n, cpu_uds_n, cpu_lds_n, cpu_rw, cpu_addr, cpu_data_in, ram_rdata,
      output cpu_data_out, cpu_data_oe, cpu_dtack_n, ram_addr, ram_wdata, ram_we_hi, ram_we_lo
   );
   modport master (
      output cpu_as_n, cpu_uds_n, cpu_lds_n, cpu_rw, cpu_addr, cpu_data_in, ram_rdata,
      input  cpu_data_out, cpu_data_oe, cpu_dtack_n, ram_addr, ram_wdata, ram_we_hi, ram_we_lo
   );
endinterface

// File: rtl/internalram_busctrl_sync2.sv
// sync2: two-flop synchroniser that resets to 1 (inactive for active-low strobes)
// Ports: clk, reset, d_i asynchronous input, q_o synchronised output
module sync2 (
   input  logic clk,
   input  logic reset,
   input  logic d_i,
   output logic q_o
);
   logic [1:0] sync_q;
   always_ff @(posedge clk)
      if (reset) sync_q <= 2'b11;
      else       sync_q <= {sync_q[0], d_i};
   assign q_o = sync_q[1];
endmodule

// File: rtl/internalram_busctrl.sv
// internalram_busctrl: sequences 68000 bus cycles onto the two byte-lane internal RAMs
// Ports: clk, reset (sync, active high), bus (slave modport: CPU pins and RAM port)
module internalram_busctrl import tang68k_pkg::*; #(
   parameter logic [23:0] BASE       = IRAM_BASE,
   parameter int          AW         = IRAM_AW,
   parameter int          RD_LATENCY = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   internalram_busctrl_if.slave  bus
);
   bus_state_e state_q;
   logic       as_s, uds_s, lds_s, rw_q, armed_q, hit;
   logic [1:0] cnt_q, vld_q;
   sync2 u_as_sync  (.clk(clk), .reset(reset), .d_i(bus.cpu_as_n),  .q_o(as_s));
   sync2 u_uds_sync (.clk(clk), .reset(reset), .d_i(bus.cpu_uds_n), .q_o(uds_s));
   sync2 u_lds_sync (.clk(clk), .reset(reset), .d_i(bus.cpu_lds_n), .q_o(lds_s));
   assign hit = bus.cpu_addr[23:AW+1] == BASE[23:AW+1];
   // vld_q marks when as_s has flushed its reset value; armed_q is set once AS is
   // genuinely seen high, so a cycle already running at reset release is ignored.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q          <= S_IDLE;
         cnt_q            <= '0;
         vld_q            <= '0;
         armed_q          <= 1'b0;
         rw_q             <= 1'b1;
         bus.cpu_dtack_n  <= 1'b1;
         bus.cpu_data_oe  <= 1'b0;
         bus.cpu_data_out <= '0;
         bus.ram_addr     <= '0;
         bus.ram_wdata    <= '0;
         bus.ram_we_hi    <= 1'b0;
         bus.ram_we_lo    <= 1'b0;
      end else begin
         vld_q         <= {vld_q[0], 1'b1};
         armed_q       <= armed_q | (vld_q[1] & as_s);
         bus.ram_we_hi <= 1'b0;
         bus.ram_we_lo <= 1'b0;
         case (state_q)
            S_IDLE: if (!as_s) begin
               bus.ram_addr <= bus.cpu_addr[AW:1];
               rw_q         <= bus.cpu_rw;
               state_q      <= armed_q ? S_DECODE : S_RELEASE;
            end
            S_DECODE: begin
               state_q <= as_s ? S_IDLE : !hit ? S_RELEASE : rw_q ? S_READ : S_WRITE;
               cnt_q   <= 2'(RD_LATENCY);
            end
            S_READ:
               if (as_s) state_q <= S_IDLE;
               else if (cnt_q == 2'd0) begin
                  bus.cpu_data_out <= bus.ram_rdata;
                  bus.cpu_data_oe  <= 1'b1;
                  bus.cpu_dtack_n  <= 1'b0;
                  state_q          <= S_ACK;
               end else cnt_q <= cnt_q - 2'd1;
            S_WRITE:
               if (as_s) state_q <= S_IDLE;
               else if (!uds_s || !lds_s) begin
                  bus.ram_wdata <= bus.cpu_data_in;
                  bus.ram_we_hi <= !uds_s;
                  bus.ram_we_lo <= !lds_s;
                  state_q       <= S_ACK;
               end
            S_ACK: begin
               bus.cpu_dtack_n <= as_s;
               if (as_s) begin
                  bus.cpu_data_oe <= 1'b0;
                  state_q         <= S_IDLE;
               end
            end
            S_RELEASE: if (as_s) state_q <= S_IDLE;
            default: state_q <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_internalram_busctrl.sv
// tb_internalram_busctrl: directed and random 68000 bus cycles against a word-memory model
module tb_internalram_busctrl;
   localparam int L = 2;
   logic clk = 1'b0, reset = 1'b1;
   always #5 clk = ~clk;
   internalram_busctrl_if #(.AW(12)) bus ();
   internalram_busctrl #(.BASE(24'h10_0000), .AW(12), .RD_LATENCY(L)) dut (
      .clk(clk), .reset(reset), .bus(bus));
   logic [15:0] ram [4096];
   logic [15:0] rd1, rd2;
   always @(posedge clk) begin
      if (bus.ram_we_hi) ram[bus.ram_addr][15:8] <= bus.ram_wdata[15:8];
      if (bus.ram_we_lo) ram[bus.ram_addr][7:0]  <= bus.ram_wdata[7:0];
      rd1 <= ram[bus.ram_addr];
      rd2 <= rd1;
   end
   assign bus.ram_rdata = rd2;
   int n_we_hi = 0, n_we_lo = 0, n_dtack_lo = 0;
   logic [15:0] last_wdata = '0;
   logic [11:0] last_waddr = '0;
   always @(negedge clk) begin
      if (bus.ram_we_hi) n_we_hi++;
      if (bus.ram_we_lo) n_we_lo++;
      if (bus.ram_we_hi || bus.ram_we_lo) begin
         last_wdata = bus.ram_wdata;
         last_waddr = bus.ram_addr;
      end
      if (!bus.cpu_dtack_n) n_dtack_lo++;
   end
   logic [15:0] model [4096];
   int n_checks = 0, n_fail = 0;
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic wait_dtack(input logic lvl, input int budget, output int n);
      n = 0;
      do begin
         tick();
         n++;
      end while (bus.cpu_dtack_n !== lvl && n < budget);
   endtask
   task automatic drive(input logic [23:0] a, input logic rw, input logic [1:0] s, input logic [15:0] d);
      bus.cpu_addr    = a[23:1];
      bus.cpu_rw      = rw;
      bus.cpu_data_in = d;
      bus.cpu_uds_n   = s[1];
      bus.cpu_lds_n   = s[0];
      bus.cpu_as_n    = 1'b0;
   endtask
   task automatic release_bus();
      bus.cpu_as_n  = 1'b1;
      bus.cpu_uds_n = 1'b1;
      bus.cpu_lds_n = 1'b1;
   endtask
   // s = {uds_n, lds_n}; window is 8 KiB starting at 0x100000
   task automatic do_cycle(input logic [23:0] a, input logic rw, input logic [1:0] s,
                           input logic [15:0] d, output logic [15:0] rd);
      int n, h0, l0, k0, w;
      logic hit;
      hit = a >= 24'h10_0000 && a < 24'h10_2000;
      w   = int'((a - 24'h10_0000) >> 1) & 4095;
      h0 = n_we_hi; l0 = n_we_lo; k0 = n_dtack_lo;
      rd = '0;
      drive(a, rw, s, d);
      if (hit) begin
         wait_dtack(1'b0, 20, n);
         check(rw ? "rd_latency" : "wr_latency", n, rw ? 5 + L : 6);
         if (rw) begin
            rd = bus.cpu_data_out;
            check("rd_data", bus.cpu_data_out, model[w]);
            check("rd_oe", bus.cpu_data_oe, 1);
         end else begin
            if (!s[1]) model[w][15:8] = d[15:8];
            if (!s[0]) model[w][7:0]  = d[7:0];
            check("wr_data", last_wdata, d);
            check("wr_addr", last_waddr, w);
         end
         release_bus();
         wait_dtack(1'b1, 10, n);
         check("ack_exit", n, 3);
         check("oe_off", bus.cpu_data_oe, 0);
      end else begin
         repeat (12) tick();
         release_bus();
         repeat (4) tick();
         check("miss_dtack", n_dtack_lo - k0, 0);
      end
      check("we_hi_count", n_we_hi - h0, hit && !rw && !s[1]);
      check("we_lo_count", n_we_lo - l0, hit && !rw && !s[0]);
   endtask
   initial begin
      int n, k0, h0, l0;
      logic [15:0] rd, d0, d1;
      logic [23:0] a;
      for (int i = 0; i < 4096; i++) begin
         ram[i] <= '0;
         model[i] = '0;
      end
      bus.cpu_addr = '0; bus.cpu_rw = 1'b1; bus.cpu_data_in = '0;
      release_bus();
      repeat (3) tick();
      check("rst_dtack", bus.cpu_dtack_n, 1);
      check("rst_oe", bus.cpu_data_oe, 0);
      check("rst_we", {bus.ram_we_hi, bus.ram_we_lo}, 0);
      check("rst_dout", bus.cpu_data_out, 0);
      check("rst_wdata", bus.ram_wdata, 0);
      check("rst_addr", bus.ram_addr, 0);
      reset = 1'b0;
      repeat (4) tick();
      do_cycle(24'h10_0010, 1'b0, 2'b00, 16'hBEEF, rd);
      do_cycle(24'h10_0010, 1'b0, 2'b10, 16'h0012, rd);
      do_cycle(24'h10_0010, 1'b1, 2'b00, 16'h0000, rd);
      check("byte_merge", rd, 16'hBE12);
      do_cycle(24'h10_1FFE, 1'b0, 2'b01, 16'hA55A, rd);
      do_cycle(24'h10_1FFE, 1'b1, 2'b00, 16'h0000, rd);
      check("top_word", rd, 16'hA500);
      do_cycle(24'h20_0000, 1'b1, 2'b00, 16'h0000, rd);
      do_cycle(24'h20_0000, 1'b0, 2'b00, 16'h1234, rd);
      do_cycle(24'h10_2000, 1'b0, 2'b00, 16'h5678, rd);
      do_cycle(24'h0F_FFFE, 1'b1, 2'b00, 16'h0000, rd);
      // abort: AS released while the FSM still waits for a data strobe
      h0 = n_we_hi; l0 = n_we_lo; k0 = n_dtack_lo;
      drive(24'h10_0020, 1'b0, 2'b11, 16'hDEAD);
      repeat (8) tick();
      release_bus();
      repeat (4) tick();
      check("abort_we", (n_we_hi - h0) + (n_we_lo - l0), 0);
      check("abort_dtack", n_dtack_lo - k0, 0);
      do_cycle(24'h10_0020, 1'b1, 2'b00, 16'h0000, rd);
      check("abort_nowrite", rd, 16'h0000);
      // reset during ACK, then a cycle still in flight at reset release
      drive(24'h10_0010, 1'b1, 2'b00, 16'h0000);
      wait_dtack(1'b0, 20, n);
      check("pre_rst_latency", n, 5 + L);
      reset = 1'b1;
      tick();
      check("rst_ack_dtack", bus.cpu_dtack_n, 1);
      check("rst_ack_oe", bus.cpu_data_oe, 0);
      reset = 1'b0;
      k0 = n_dtack_lo;
      repeat (12) tick();
      check("halfseen_dtack", n_dtack_lo - k0, 0);
      release_bus();
      repeat (4) tick();
      do_cycle(24'h10_0010, 1'b1, 2'b00, 16'h0000, rd);
      // back-to-back reads with one clock of AS high between them
      d0 = 16'($urandom); d1 = 16'($urandom);
      do_cycle(24'h10_0040, 1'b0, 2'b00, d0, rd);
      do_cycle(24'h10_0042, 1'b0, 2'b00, d1, rd);
      drive(24'h10_0040, 1'b1, 2'b00, 16'h0000);
      wait_dtack(1'b0, 20, n);
      check("b2b_lat1", n, 5 + L);
      check("b2b_data1", bus.cpu_data_out, d0);
      bus.cpu_as_n = 1'b1;
      tick();
      drive(24'h10_0042, 1'b1, 2'b00, 16'h0000);
      wait_dtack(1'b1, 10, n);
      check("b2b_release", n, 2);
      wait_dtack(1'b0, 20, n);
      check("b2b_lat2", n, L + 3);
      check("b2b_data2", bus.cpu_data_out, d1);
      release_bus();
      wait_dtack(1'b1, 10, n);
      check("b2b_exit", n, 3);
      for (int i = 0; i < 40; i++) begin
         a = ($urandom_range(0, 7) == 0) ? 24'h30_0000 + 24'($urandom_range(0, 255) * 2)
                                         : 24'h10_0000 + 24'($urandom_range(0, 15) * 2);
         do_cycle(a, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 2)), 16'($urandom), rd);
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/internalram_busctrl.md
# internalram_busctrl

Bus-cycle sequencer between the asynchronous 68000 bus and the two byte-lane internal block RAMs. Synchronises the CPU strobes and decodes the internal-RAM window. Issues per-lane write pulses or timed reads, then drives DTACK and the read-data enable until the CPU ends the cycle. Sits between the CPU pin interface and the internal RAM instance; it is the only master of the RAM ports.

## Interface
Parameters:
- BASE, 24'h10_0000: byte base address of the RAM window; aligned to window size.
- AW, 12: RAM word-address width; window = 2^(AW+1) bytes.
- RD_LATENCY, 1: clocks from RAM address valid to ram_rdata valid (1..3).

Ports:
- clk  in  1  system clock; sole clock; all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- cpu_as_n  in  1  address strobe, asynchronous.
- cpu_uds_n  in  1  upper data strobe, asynchronous.
- cpu_lds_n  in  1  lower data strobe, asynchronous.
- cpu_rw  in  1  1 = read, 0 = write.
- cpu_addr  in  23  address bits A23..A1.
- cpu_data_in  in  16  write data from CPU.
- cpu_data_out  out  16  registered read data to CPU.
- cpu_data_oe  out  1  data bus output enable.
- cpu_dtack_n  out  1  data transfer acknowledge, active low.
- ram_addr  out  AW  RAM word address.
- ram_wdata  out  16  RAM write data.
- ram_we_hi  out  1  write strobe for the D15..D8 lane.
- ram_we_lo  out  1  write strobe for the D7..D0 lane.
- ram_rdata  in  16  RAM read data {high, low}.

## Operation
- as_n, uds_n and lds_n each pass a 2-flop synchroniser (as_s, uds_s, lds_s). Synchronisers reset to 1.
- All other cpu_* inputs are sampled only when as_s is low, which guarantees they are stable.
- States: IDLE, DECODE, READ, WRITE, ACK, RELEASE.
- IDLE: on as_s == 0, latch cpu_addr[AW:1] into ram_addr and latch cpu_rw. Go to DECODE.
- DECODE:
  - hit = (cpu_addr[23:AW+1] == BASE[23:AW+1]).
  - Hit and read: go to READ and load the wait counter with RD_LATENCY.
  - Hit and write: go to WRITE.
  - Miss: go to RELEASE without asserting DTACK. Bus error belongs to the system watchdog.
- READ: decrement the counter each clock. At zero, register ram_rdata into cpu_data_out, set cpu_data_oe = 1, go to ACK.
- WRITE:
  - Wait for uds_s == 0 or lds_s == 0.
  - On that clock, register cpu_data_in into ram_wdata and pulse ram_we_hi = !uds_s and ram_we_lo = !lds_s for exactly one clock. Go to ACK.
  - Both strobes low means a word write.
- ACK: cpu_dtack_n = 0. Hold until as_s == 1, then go to IDLE. On that transition cpu_dtack_n returns to 1 and cpu_data_oe to 0.
- RELEASE: all outputs inactive. Go to IDLE when as_s == 1.
- Abort: as_s == 1 while in DECODE, READ or WRITE (before the strobe) returns the FSM to IDLE. No write occurs and DTACK is never asserted.
- Reset, including mid-cycle: FSM = IDLE. Reset values:
  - cpu_dtack_n = 1, cpu_data_oe = 0.
  - ram_we_hi = ram_we_lo = 0.
  - cpu_data_out = 0, ram_wdata = 0, ram_addr = 0.
  - counter = 0.
- A CPU cycle already in progress when reset releases is treated as a miss (RELEASE). The FSM never acknowledges a half-seen cycle.

## Timing
- Let T0 = the clock where as_s is first sampled low.
- DECODE is at T0+1.
- Read: cpu_dtack_n falls at T0+2+RD_LATENCY. cpu_data_out is valid on the same edge.
- Write: ram_we_* pulse on the first clock where the strobe is seen synchronised low, no earlier than T0+2. cpu_dtack_n falls on the next edge.
- ACK exit: DTACK deasserts one clock after as_s rises, i.e. 3 clocks after the as_n pin rises.
- Back-to-back cycles: the next cycle may start in the IDLE clock immediately following ACK. No dead cycle is added.
- Write pulses are never wider than 1 clock and are never issued outside WRITE.

## Structure
- Shared package tang68k_pkg holds:
  - FSM state encoding localparams (3-bit, binary).
  - the internal-RAM BASE/AW defaults, shared with the address decoder and memory map.
- Sub-module sync2: a 2-flop synchroniser with reset-to-1. Instantiate it three times (AS, UDS, LDS).
- The FSM, counter and output registers live in this module.

## Test plan
- Word write: addr 0x100010, data 0xBEEF, UDS = LDS = 0 → ram_addr 0x008; ram_we_hi and ram_we_lo both pulse once with ram_wdata 0xBEEF; DTACK low until AS high.
- Byte write, low lane: LDS = 0, UDS = 1, data 0x0012 → only ram_we_lo pulses. A subsequent word read returns 0xBE12.
- Read with RD_LATENCY = 2: DTACK falls exactly at T0+4; cpu_data_out equals the RAM model contents; oe drops with DTACK.
- Miss: addr 0x200000 → no we pulse and DTACK stays high; FSM returns to IDLE after AS releases.
- Abort and reset: AS released during WRITE before the strobes → no write. Reset asserted during ACK → DTACK high and oe 0 on the next edge.
- Back-to-back: two reads with one clock of AS high between them → both acknowledged with correct data; no extra idle cycle.
